// File: rtl/ff_t_seq_gen.sv
// ff_t_seq_gen: serial stimulus sequencer for the downstream FF_T stage.
// Plays a loaded pattern LSB first on a registered t output, with
// programmable length, single-shot or looping playback, hold and abort.
module ff_t_seq_gen #(
  parameter int WIDTH = 16,
  parameter int LW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    len,
  input  logic             start,
  input  logic             loop,
  input  logic             hold,
  input  logic             stop,
  output logic             t,
  output logic             busy,
  output logic             done,
  output logic [LW-1:0]    idx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d, pat_sh;
  logic [LW-1:0]    len_q, len_d, len_clamp, last_idx;
  logic [LW-1:0]    idx_q, idx_d;
  logic             t_q, t_d;

  // Over-long requests play the whole register rather than wrapping.
  assign len_clamp = (len > LW'(WIDTH)) ? LW'(WIDTH) : len;
  assign last_idx  = len_q - LW'(1);
  // Next bit to present; shifting avoids an over-wide bit-select index.
  assign pat_sh    = pat_q >> (idx_q + LW'(1));

  // State, pattern, length, index and serial bit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      t_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      t_q     <= t_d;
    end
  end

  // Next-state and datapath: load/start only outside RUN, stop beats
  // hold, loop and end-of-sequence while running.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    t_d     = t_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE is a single-cycle marker; without a start we fall to IDLE.
        state_d = S_IDLE;
        t_d     = 1'b0;
        idx_d   = '0;
        if (load) begin
          pat_d = pattern;
          len_d = len_clamp;
        end
        // Same-edge load+start uses the freshly loaded values.
        if (start && (len_d != '0)) begin
          state_d = S_RUN;
          t_d     = pat_d[0];
          idx_d   = '0;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          t_d     = 1'b0;
          idx_d   = '0;
        end else if (!hold) begin
          if (idx_q < last_idx) begin
            idx_d = idx_q + LW'(1);
            t_d   = pat_sh[0];
          end else if (loop) begin
            idx_d = '0;
            t_d   = pat_q[0];
          end else begin
            state_d = S_DONE;
            t_d     = 1'b0;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        t_d     = 1'b0;
        idx_d   = '0;
      end
    endcase
  end

  assign t    = t_q;
  assign idx  = idx_q;
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_ff_t_seq_gen.sv
// tb_ff_t_seq_gen: directed plus random stimulus against a queue-based
// playback model; also models the downstream FF_T toggle stage.
module tb_ff_t_seq_gen;

  localparam int WIDTH = 16;
  localparam int LW    = $clog2(WIDTH) + 1;

  logic             clk;
  logic             rst, load, start, loop, hold, stop;
  logic [WIDTH-1:0] pattern;
  logic [LW-1:0]    len;
  logic             t, busy, done;
  logic [LW-1:0]    idx;
  logic             ffq;

  int errs   = 0;
  int checks = 0;

  ff_t_seq_gen #(.WIDTH(WIDTH), .LW(LW)) dut (
    .clk(clk), .rst(rst), .load(load), .pattern(pattern), .len(len),
    .start(start), .loop(loop), .hold(hold), .stop(stop),
    .t(t), .busy(busy), .done(done), .idx(idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream FF_T stage fed by t.
  always_ff @(posedge clk) begin
    if (rst) ffq <= 1'b0;
    else     ffq <= ffq ^ t;
  end

  // Reference model: remaining bits of the current pass held in a queue,
  // head of the queue is the bit on t.
  bit             m_run, m_done, m_t, m_ffq;
  logic [WIDTH-1:0] m_pat;
  int             m_len, m_idx;
  bit             m_q[$];

  task automatic m_fill();
    m_q.delete();
    for (int i = 0; i < m_len; i++) m_q.push_back(m_pat[i]);
  endtask

  task automatic m_step();
    m_ffq = rst ? 1'b0 : (m_ffq ^ m_t);
    if (rst) begin
      m_run = 0; m_done = 0; m_pat = '0; m_len = 0; m_q.delete();
      m_t = 0; m_idx = 0;
    end else begin
      m_done = 0;
      if (m_run) begin
        if (stop) begin
          m_run = 0; m_q.delete(); m_t = 0; m_idx = 0;
        end else if (!hold) begin
          void'(m_q.pop_front());
          if (m_q.size() > 0) begin
            m_t = m_q[0]; m_idx = m_len - m_q.size();
          end else if (loop) begin
            m_fill(); m_t = m_q[0]; m_idx = 0;
          end else begin
            m_run = 0; m_done = 1; m_t = 0; m_idx = 0;
          end
        end
      end else begin
        m_t = 0; m_idx = 0;
        if (load) begin
          m_pat = pattern;
          m_len = (int'(len) > WIDTH) ? WIDTH : int'(len);
        end
        if (start && m_len > 0) begin
          m_fill(); m_run = 1; m_t = m_q[0]; m_idx = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: model steps on the edge, outputs compared 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    m_step();
    #1;
    chk("t",    32'(t),    32'(m_t));
    chk("busy", 32'(busy), 32'(m_run));
    chk("done", 32'(done), 32'(m_done));
    chk("idx",  32'(idx),  32'(m_idx));
    chk("ffq",  32'(ffq),  32'(m_ffq));
  endtask

  task automatic clr_in();
    rst = 0; load = 0; start = 0; loop = 0; hold = 0; stop = 0;
    pattern = '0; len = '0;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  int bcnt, dcnt;
  logic [14:0] ss_seq;

  initial begin
    clr_in();
    m_run = 0; m_done = 0; m_t = 0; m_ffq = 0; m_idx = 0; m_len = 0; m_pat = '0;

    // Reset and idle
    rst = 1; run_n(2);
    rst = 0; run_n(5);

    // Single shot, 15 bits
    load = 1; pattern = 16'b0101001110011111; len = 15; cyc();
    load = 0; start = 1; cyc();
    start = 0;
    bcnt = 0; dcnt = 0; ss_seq = '0;
    for (int i = 0; i < 18; i++) begin
      if (busy) begin
        if (bcnt < 15) ss_seq[bcnt] = t;
        bcnt++;
      end
      if (done) dcnt++;
      cyc();
    end
    chk("ss_seq",  32'(ss_seq), 32'(15'b101001110011111));
    chk("ss_busy", 32'(bcnt), 32'd15);
    chk("ss_done", 32'(dcnt), 32'd1);
    chk("ss_ffq",  32'(ffq), 32'(^15'b101001110011111));

    // Loop with hold at idx 1
    load = 1; pattern = 16'h0003; len = 3; loop = 1; start = 1; cyc();
    load = 0; start = 0; cyc();
    hold = 1; run_n(2);
    hold = 0; run_n(8);
    loop = 0; run_n(5);

    // Stop at idx 4 of a 10-bit run
    load = 1; pattern = 16'hA5C3; len = 10; start = 1; cyc();
    load = 0; start = 0; run_n(4);
    stop = 1; cyc();
    stop = 0; run_n(2);

    // Load during RUN must not alter playback
    load = 1; pattern = 16'h00F0; len = 8; start = 1; cyc();
    start = 0; pattern = 16'hFF0F; len = 12; run_n(3);
    load = 0; run_n(8);

    // Reset at idx 2
    load = 1; pattern = 16'hFFFF; len = 10; start = 1; cyc();
    load = 0; start = 0; run_n(2);
    rst = 1; cyc();
    rst = 0; run_n(2);

    // Length boundaries: 0, over-long, 1
    load = 1; pattern = 16'hFFFF; len = 0; start = 1; cyc();
    load = 0; run_n(2);
    start = 0;
    load = 1; pattern = 16'h8001; len = 20; start = 1; cyc();
    load = 0; start = 0; run_n(18);
    load = 1; pattern = 16'h0001; len = 1; start = 1; cyc();
    load = 0; start = 0; run_n(3);

    // Back-to-back: start in the DONE cycle
    load = 1; pattern = 16'h0007; len = 3; start = 1; cyc();
    load = 0; start = 0; run_n(2);
    cyc();
    chk("b2b_done", 32'(done), 32'd1);
    start = 1; cyc();
    start = 0; run_n(4);

    // Same-edge load+start
    load = 1; pattern = 16'h0002; len = 2; start = 1; cyc();
    load = 0; start = 0;
    chk("ls_t0", 32'(t), 32'd0);
    cyc();
    chk("ls_t1", 32'(t), 32'd1);
    run_n(3);

    // Random stimulus
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(199) == 0);
      load    = ($urandom_range(7) == 0);
      start   = ($urandom_range(5) == 0);
      stop    = ($urandom_range(29) == 0);
      hold    = ($urandom_range(4) == 0);
      loop    = $urandom_range(1);
      len     = LW'($urandom_range(20));
      pattern = WIDTH'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
